// File: rtl/at25010_seq_pkg.sv
// Shared AT25010 command encodings and status-register bit positions, used by the
// sequencer and the EEPROM interface.
package at25010_seq_pkg;

  localparam logic [2:0] CmdWren  = 3'b000;
  localparam logic [2:0] CmdWrdi  = 3'b001;
  localparam logic [2:0] CmdRdsr  = 3'b010;
  localparam logic [2:0] CmdWrsr  = 3'b011;
  localparam logic [2:0] CmdRead  = 3'b100;
  localparam logic [2:0] CmdWrite = 3'b101;

  localparam int unsigned StatBusy = 0;  // RDY_n
  localparam int unsigned StatWel  = 1;

  // At least one poll is always made; the 8-bit poll counter caps the limit at 255.
  function automatic logic [7:0] eff_max_polls(input int unsigned max_polls);
    if (max_polls == 0) begin
      return 8'd1;
    end else if (max_polls > 255) begin
      return 8'd255;
    end else begin
      return 8'(max_polls);
    end
  endfunction

endpackage

// File: rtl/at25010_seq.sv
// Byte read/write sequencer for an AT25010 SPI EEPROM: issues WREN/WRITE then polls RDSR
// until the device is ready, or a single READ, and returns one response per request.
module at25010_seq
  import at25010_seq_pkg::*;
#(
  parameter int unsigned MAX_POLLS     = 255,
  parameter int unsigned POLL_GAP_CLKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic       cmd_valid,
  output logic [2:0] cmd_type,
  output logic [6:0] cmd_addr,
  output logic [7:0] cmd_wdata,
  input  logic       cmd_ready,
  input  logic [7:0] cmd_rdata,
  input  logic       cmd_done,
  input  logic       cmd_error
);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StRdCmd    = 4'd1;
  localparam logic [3:0] StRdWait   = 4'd2;
  localparam logic [3:0] StWrenCmd  = 4'd3;
  localparam logic [3:0] StWrenWait = 4'd4;
  localparam logic [3:0] StWrCmd    = 4'd5;
  localparam logic [3:0] StWrWait   = 4'd6;
  localparam logic [3:0] StGap      = 4'd7;
  localparam logic [3:0] StPollCmd  = 4'd8;
  localparam logic [3:0] StPollWait = 4'd9;
  localparam logic [3:0] StResp     = 4'd10;

  localparam logic [7:0]  MaxPolls = eff_max_polls(MAX_POLLS);
  localparam logic [15:0] GapLoad  = 16'(POLL_GAP_CLKS);

  logic [3:0]  state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  poll_q, poll_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        req_ready_q;
  logic        last_poll;

  assign last_poll = ({1'b0, poll_q} + 9'd1) >= {1'b0, MaxPolls};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    poll_d  = poll_q;
    gap_d   = gap_q;
    rdata_d = rdata_q;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_write ? req_wdata : 8'h00;
          rdata_d = 8'h00;
          error_d = 1'b0;
          state_d = req_write ? StWrenCmd : StRdCmd;
        end
      end
      StRdCmd:    if (cmd_ready) state_d = StRdWait;
      StWrenCmd:  if (cmd_ready) state_d = StWrenWait;
      StWrCmd:    if (cmd_ready) state_d = StWrWait;
      StPollCmd:  if (cmd_ready) state_d = StPollWait;
      // Error outranks a simultaneous done in every wait state.
      StRdWait: begin
        if (cmd_error) begin
          error_d = 1'b1;
          state_d = StResp;
        end else if (cmd_done) begin
          rdata_d = cmd_rdata;
          state_d = StResp;
        end
      end
      StWrenWait: begin
        if (cmd_error) begin
          error_d = 1'b1;
          state_d = StResp;
        end else if (cmd_done) begin
          state_d = StWrCmd;
        end
      end
      StWrWait: begin
        if (cmd_error) begin
          error_d = 1'b1;
          state_d = StResp;
        end else if (cmd_done) begin
          poll_d  = 8'd0;
          gap_d   = GapLoad;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q <= 16'd1) begin
          state_d = StPollCmd;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      StPollWait: begin
        if (cmd_error) begin
          error_d = 1'b1;
          state_d = StResp;
        end else if (cmd_done) begin
          if (!cmd_rdata[StatBusy]) begin
            state_d = StResp;
          end else if (last_poll) begin
            error_d = 1'b1;
            state_d = StResp;
          end else begin
            poll_d  = poll_q + 8'd1;
            gap_d   = GapLoad;
            state_d = StGap;
          end
        end
      end
      StResp:     if (rsp_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= 7'd0;
      wdata_q     <= 8'd0;
      poll_q      <= 8'd0;
      gap_q       <= 16'd0;
      rdata_q     <= 8'd0;
      error_q     <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      poll_q      <= poll_d;
      gap_q       <= gap_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
      req_ready_q <= (state_d == StIdle);
    end
  end

  always_comb begin
    cmd_valid = 1'b0;
    cmd_type  = CmdWren;
    cmd_addr  = 7'd0;
    cmd_wdata = 8'd0;
    unique case (state_q)
      StRdCmd: begin
        cmd_valid = 1'b1;
        cmd_type  = CmdRead;
        cmd_addr  = addr_q;
      end
      StWrenCmd: begin
        cmd_valid = 1'b1;
        cmd_type  = CmdWren;
      end
      StWrCmd: begin
        cmd_valid = 1'b1;
        cmd_type  = CmdWrite;
        cmd_addr  = addr_q;
        cmd_wdata = wdata_q;
      end
      StPollCmd: begin
        cmd_valid = 1'b1;
        cmd_type  = CmdRdsr;
      end
      default: ;
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

endmodule

// File: tb/tb_at25010_seq.sv
// Randomized bench for at25010_seq: a downstream EEPROM responder logs every command and a
// transaction-level model predicts the command list and the response.
module tb_at25010_seq;

  localparam int unsigned MAXP = 4;
  localparam int unsigned GAP  = 16;
  localparam logic [2:0] T_WREN  = 3'b000;
  localparam logic [2:0] T_RDSR  = 3'b010;
  localparam logic [2:0] T_READ  = 3'b100;
  localparam logic [2:0] T_WRITE = 3'b101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_error;
  logic [7:0] rsp_rdata;
  logic       cmd_valid, cmd_ready, cmd_done, cmd_error;
  logic [2:0] cmd_type;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata, cmd_rdata;

  always #5 clk = ~clk;

  at25010_seq #(
    .MAX_POLLS    (MAXP),
    .POLL_GAP_CLKS(GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .cmd_valid(cmd_valid),
    .cmd_type (cmd_type),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_ready(cmd_ready),
    .cmd_rdata(cmd_rdata),
    .cmd_done (cmd_done),
    .cmd_error(cmd_error)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0] t;
    logic [6:0] a;
    logic [7:0] d;
    int         gap;
  } cmd_rec_t;

  // Responder configuration, set by the main thread before each transaction.
  int         ready_hold = 0;
  int         done_dly = 0;
  int         busy_polls = 0;
  int         err_idx = -1;
  bit         err_both = 0;
  bit         stray_en = 0;
  logic [7:0] rd_data = 8'h00;

  cmd_rec_t   log_q[$];
  int         rdsr_cnt = 0;
  int         viol = 0;
  bit         pending = 0;

  // Downstream EEPROM interface model; acts on the falling edge.
  initial begin
    int         cyc, last_done_cyc, dly_cnt, hold_cnt;
    bit         in_cmd, hs_prev, pend_err;
    logic [7:0] pend_data;
    cmd_rec_t   cur;
    cyc = 0; last_done_cyc = 0; dly_cnt = 0; hold_cnt = 0;
    in_cmd = 0; hs_prev = 0; pend_err = 0; pend_data = 0;
    cur = '{3'b0, 7'b0, 8'b0, 0};
    cmd_ready = 0; cmd_done = 0; cmd_error = 0; cmd_rdata = 0;
    forever begin
      @(negedge clk);
      cyc++;
      cmd_ready = 0;
      cmd_done  = 0;
      cmd_error = 0;
      cmd_rdata = 8'($urandom);
      if (rst) begin
        pending = 0; in_cmd = 0; hs_prev = 0;
        continue;
      end
      if (hs_prev && cmd_valid) viol++;
      hs_prev = 0;
      if (in_cmd && !cmd_valid) begin
        viol++;
        in_cmd = 0;
      end
      if (pending) begin
        if (dly_cnt == 0) begin
          pending = 0;
          last_done_cyc = cyc;
          if (pend_err) begin
            cmd_error = 1;
            cmd_done  = err_both;
          end else begin
            cmd_done  = 1;
            cmd_rdata = pend_data;
          end
        end else begin
          dly_cnt--;
        end
      end else if (cmd_valid) begin
        if (!in_cmd) begin
          in_cmd = 1;
          hold_cnt = 0;
          cur = '{cmd_type, cmd_addr, cmd_wdata, cyc - last_done_cyc - 1};
        end else if (cmd_type !== cur.t || cmd_addr !== cur.a || cmd_wdata !== cur.d) begin
          viol++;
        end
        if (hold_cnt < ready_hold) begin
          hold_cnt++;
        end else begin
          cmd_ready = 1;
          hs_prev = 1;
          in_cmd = 0;
          pending = 1;
          dly_cnt = done_dly;
          log_q.push_back(cur);
          pend_err = (log_q.size() - 1 == err_idx);
          pend_data = 8'($urandom);
          if (cur.t == T_READ) pend_data = rd_data;
          if (cur.t == T_RDSR) begin
            pend_data[0] = (rdsr_cnt < busy_polls);
            rdsr_cnt++;
          end
        end
      end else if (stray_en && $urandom_range(0, 7) == 0) begin
        // Pulses outside a wait state must be ignored by the sequencer.
        cmd_done  = 1'($urandom);
        cmd_error = 1'($urandom);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input bit wr, input logic [6:0] a, input logic [7:0] d,
                         input int rsp_hold);
    cmd_rec_t   exp_q[$];
    bit         exp_err;
    logic [7:0] exp_rd;
    int         npoll, n;
    exp_q = {};
    exp_err = 0;
    if (!wr) begin
      exp_q.push_back('{T_READ, a, 8'h00, 0});
      exp_rd = rd_data;
    end else begin
      exp_rd = 8'h00;
      exp_q.push_back('{T_WREN, 7'h00, 8'h00, 0});
      exp_q.push_back('{T_WRITE, a, d, 0});
      npoll = (busy_polls + 1 < int'(MAXP)) ? busy_polls + 1 : int'(MAXP);
      exp_err = (busy_polls >= int'(MAXP));
      for (int i = 0; i < npoll; i++) exp_q.push_back('{T_RDSR, 7'h00, 8'h00, int'(GAP)});
    end
    if (err_idx >= 0 && err_idx < exp_q.size()) begin
      while (exp_q.size() > err_idx + 1) exp_q.pop_back();
      exp_err = 1;
    end

    log_q.delete();
    rdsr_cnt = 0;
    viol = 0;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d;
    tick();
    req_valid = 0; req_addr = 7'($urandom); req_wdata = 8'($urandom);
    check_eq("req_ready_busy", 32'(req_ready), 32'd0);

    n = 0;
    while (!rsp_valid && n < 2000) begin
      tick();
      n++;
    end
    if (!rsp_valid) begin
      check_eq("rsp_timeout", 32'(rsp_valid), 32'd1);
      rst = 1; tick(); tick(); rst = 0; tick();
      return;
    end
    for (int k = 0; k <= rsp_hold; k++) begin
      if (k > 0) tick();
      check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("rsp_error", 32'(rsp_error), 32'(exp_err));
      if (!(exp_err && !wr)) check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check_eq("rsp_drop", 32'(rsp_valid), 32'd0);
    check_eq("req_ready_back", 32'(req_ready), 32'd1);

    check_eq("cmd_count", 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check_eq("cmd_type", 32'(log_q[i].t), 32'(exp_q[i].t));
      if (exp_q[i].t == T_READ || exp_q[i].t == T_WRITE)
        check_eq("cmd_addr", 32'(log_q[i].a), 32'(exp_q[i].a));
      if (exp_q[i].t == T_WRITE) check_eq("cmd_wdata", 32'(log_q[i].d), 32'(exp_q[i].d));
      if (exp_q[i].t == T_RDSR) check_eq("poll_gap", 32'(log_q[i].gap), 32'(exp_q[i].gap));
    end
    check_eq("cmd_protocol", 32'(viol), 32'd0);
  endtask

  task automatic cfg(input int rh, input int dd, input int bp, input int ei, input bit eb,
                     input logic [7:0] rd);
    ready_hold = rh; done_dly = dd; busy_polls = bp; err_idx = ei; err_both = eb; rd_data = rd;
  endtask

  initial begin
    int sz, n;
    repeat (3) tick();
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check_eq("rst_cmd_type", 32'(cmd_type), 32'd0);
    check_eq("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    check_eq("rst_cmd_wdata", 32'(cmd_wdata), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("rst_rsp_error", 32'(rsp_error), 32'd0);
    rst = 0;
    tick();
    check_eq("rst_release_ready", 32'(req_ready), 32'd1);

    cfg(0, 0, 0, -1, 0, 8'hA5); run_txn(0, 7'h15, 8'h00, 0);   // plain read
    cfg(0, 0, 3, -1, 0, 8'h00); run_txn(1, 7'h7F, 8'h3C, 0);   // busy for 3 polls
    cfg(0, 1, 100, -1, 0, 8'h00); run_txn(1, 7'h22, 8'h11, 1); // stuck busy: timeout
    cfg(0, 0, 0, 0, 0, 8'h00); run_txn(1, 7'h01, 8'h02, 0);    // error during WREN
    cfg(10, 0, 1, -1, 0, 8'h00); run_txn(1, 7'h40, 8'h9B, 5);  // slow ready, slow host
    cfg(0, 2, 0, 0, 1, 8'h77); run_txn(0, 7'h33, 8'h00, 0);    // done+error together

    stray_en = 1;
    for (int i = 0; i < 30; i++) begin
      cfg($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 5),
          ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1,
          1'($urandom), 8'($urandom));
      run_txn(1'($urandom), 7'($urandom), 8'($urandom), $urandom_range(0, 3));
    end
    stray_en = 0;

    // Reset while waiting between polls.
    cfg(0, 0, 100, -1, 0, 8'h00);
    log_q.delete();
    rdsr_cnt = 0;
    req_valid = 1; req_write = 1; req_addr = 7'h0A; req_wdata = 8'h55;
    tick();
    req_valid = 0;
    n = 0;
    while ((log_q.size() < 2 || pending) && n < 100) begin
      tick();
      n++;
    end
    check_eq("gap_reach", 32'(log_q.size()), 32'd2);
    repeat (3) tick();
    rst = 1;
    tick();
    check_eq("gaprst_req_ready", 32'(req_ready), 32'd0);
    check_eq("gaprst_cmd_valid", 32'(cmd_valid), 32'd0);
    check_eq("gaprst_cmd_type", 32'(cmd_type), 32'd0);
    check_eq("gaprst_cmd_addr", 32'(cmd_addr), 32'd0);
    check_eq("gaprst_cmd_wdata", 32'(cmd_wdata), 32'd0);
    check_eq("gaprst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("gaprst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("gaprst_rsp_error", 32'(rsp_error), 32'd0);
    rst = 0;
    sz = log_q.size();
    repeat (30) tick();
    check_eq("gaprst_no_cmd", 32'(log_q.size()), 32'(sz));
    check_eq("gaprst_no_rsp", 32'(rsp_valid), 32'd0);
    cfg(0, 0, 0, -1, 0, 8'hC3); run_txn(0, 7'h6E, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
